// File: rtl/param_updn_counter.sv
// param_updn_counter: bounded up/down counter with clamped load, wrap or saturate at the bounds,
// one-cycle overflow/underflow pulses and a sticky error flag.
module param_updn_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ld_cnt,
  input  logic              count_enb,
  input  logic              updn_cnt,
  input  logic [STEP_W-1:0] step,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              ovf,
  output logic              unf,
  output logic              err_sticky
);
  localparam int XW = WIDTH + 2;
  localparam logic [XW-1:0] MIN_X = XW'(MIN_VAL);
  localparam logic [XW-1:0] MAX_X = XW'(MAX_VAL);
  localparam logic [XW-1:0] SPAN = XW'(MAX_VAL - MIN_VAL + 1);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  if (!(MIN_VAL < MAX_VAL && MAX_VAL <= 2**WIDTH-1 && 2**STEP_W-1 <= MAX_VAL-MIN_VAL)) begin : g_bad_params
    $error("param_updn_counter: illegal WIDTH/STEP_W/MIN_VAL/MAX_VAL combination");
  end
  logic [XW-1:0]    sum, diff;
  logic [WIDTH-1:0] up_wrap, dn_wrap, ld_val, nxt;
  logic             over, under, nxt_ovf, nxt_unf;
  // Wrapping by one span keeps the result inside [MIN_VAL, MAX_VAL] since step never exceeds the span.
  always_comb begin
    sum     = {2'b00, data_out} + XW'(step);
    diff    = {2'b00, data_out} - XW'(step);
    up_wrap = WIDTH'(sum - SPAN);
    dn_wrap = WIDTH'(diff + SPAN);
    over    = sum > MAX_X;
    under   = $signed(diff) < $signed(MIN_X);
    ld_val  = $signed({2'b00, data_in}) < $signed(MIN_X) ? MIN_W :
              $signed({2'b00, data_in}) > $signed(MAX_X) ? MAX_W : data_in;
    nxt_ovf = !ld_cnt && count_enb && updn_cnt && over;
    nxt_unf = !ld_cnt && count_enb && !updn_cnt && under;
    nxt     = ld_cnt     ? ld_val :
              !count_enb ? data_out :
              updn_cnt   ? (over ? (SATURATE != 0 ? MAX_W : up_wrap) : sum[WIDTH-1:0]) :
                           (under ? (SATURATE != 0 ? MIN_W : dn_wrap) : diff[WIDTH-1:0]);
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_out   <= MIN_W;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      data_out   <= nxt;
      ovf        <= nxt_ovf;
      unf        <= nxt_unf;
      err_sticky <= nxt_ovf | nxt_unf | (err_sticky & ~clr_err);
    end
  end
  assign tc_up = data_out == MAX_W;
  assign tc_dn = data_out == MIN_W;
endmodule

// File: tb/tb_param_updn_counter.sv
// tb_param_updn_counter: wrap and saturate instances driven in lockstep, checked by a queued scoreboard.
module tb_param_updn_counter;
  localparam int MN = 10;
  localparam int MX = 20;
  logic clk = 0, rst_ = 0, ld_cnt = 0, count_enb = 0, updn_cnt = 0, clr_err = 0;
  logic [7:0] data_in = 0;
  logic [2:0] step = 0;
  logic [7:0] dout [2];
  logic tc_up [2], tc_dn [2], ovf [2], unf [2], err [2];
  typedef struct packed {
    logic [1:0][7:0] c;
    logic [1:0] o, u, e;
  } exp_t;
  exp_t q [$];
  exp_t me;
  int m_cnt [2];
  bit m_ovf [2], m_unf [2], m_err [2];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  param_updn_counter #(.WIDTH(8), .STEP_W(3), .MIN_VAL(MN), .MAX_VAL(MX), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_(rst_), .data_in(data_in), .ld_cnt(ld_cnt), .count_enb(count_enb),
    .updn_cnt(updn_cnt), .step(step), .clr_err(clr_err), .data_out(dout[0]), .tc_up(tc_up[0]),
    .tc_dn(tc_dn[0]), .ovf(ovf[0]), .unf(unf[0]), .err_sticky(err[0]));
  param_updn_counter #(.WIDTH(8), .STEP_W(3), .MIN_VAL(MN), .MAX_VAL(MX), .SATURATE(1)) u_sat (
    .clk(clk), .rst_(rst_), .data_in(data_in), .ld_cnt(ld_cnt), .count_enb(count_enb),
    .updn_cnt(updn_cnt), .step(step), .clr_err(clr_err), .data_out(dout[1]), .tc_up(tc_up[1]),
    .tc_dn(tc_dn[1]), .ovf(ovf[1]), .unf(unf[1]), .err_sticky(err[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = MN;
      m_ovf[s] = 0;
      m_unf[s] = 0;
      m_err[s] = 0;
    end
  endtask

  // Reference behaviour: index 0 wraps, index 1 saturates.
  task automatic model_step(input bit ld, input bit enb, input bit up, input int st, input int din, input bit clr);
    for (int s = 0; s < 2; s++) begin
      int t;
      m_ovf[s] = 0;
      m_unf[s] = 0;
      if (ld) m_cnt[s] = din < MN ? MN : din > MX ? MX : din;
      else if (enb && up) begin
        t = m_cnt[s] + st;
        if (t > MX) begin
          m_ovf[s] = 1;
          m_cnt[s] = s == 1 ? MX : MN + (t - MX - 1);
        end else m_cnt[s] = t;
      end else if (enb) begin
        t = m_cnt[s] - st;
        if (t < MN) begin
          m_unf[s] = 1;
          m_cnt[s] = s == 1 ? MN : MX - (MN - t - 1);
        end else m_cnt[s] = t;
      end
      m_err[s] = m_ovf[s] | m_unf[s] | (m_err[s] & !clr);
    end
  endtask

  task automatic drive(input bit ld, input bit enb, input bit up, input logic [2:0] st, input logic [7:0] din, input bit clr);
    exp_t e;
    ld_cnt = ld;
    count_enb = enb;
    updn_cnt = up;
    step = st;
    data_in = din;
    clr_err = clr;
    model_step(ld, enb, up, int'(st), int'(din), clr);
    for (int s = 0; s < 2; s++) begin
      e.c[s] = 8'(m_cnt[s]);
      e.o[s] = m_ovf[s];
      e.u[s] = m_unf[s];
      e.e[s] = m_err[s];
    end
    @(posedge clk);
    q.push_back(e);
  endtask

  task automatic cyc(input bit ld, input bit enb, input bit up, input logic [2:0] st, input logic [7:0] din, input bit clr);
    @(negedge clk);
    drive(ld, enb, up, st, din, clr);
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      me = q.pop_front();
      for (int s = 0; s < 2; s++) begin
        check($sformatf("sb data_out[%0d]", s), 32'(dout[s]), 32'(me.c[s]));
        check($sformatf("sb ovf[%0d]", s), 32'(ovf[s]), 32'(me.o[s]));
        check($sformatf("sb unf[%0d]", s), 32'(unf[s]), 32'(me.u[s]));
        check($sformatf("sb err_sticky[%0d]", s), 32'(err[s]), 32'(me.e[s]));
        check($sformatf("sb tc_up[%0d]", s), 32'(tc_up[s]), 32'(me.c[s] == 8'(MX)));
        check($sformatf("sb tc_dn[%0d]", s), 32'(tc_dn[s]), 32'(me.c[s] == 8'(MN)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset data_out[%0d]", s), 32'(dout[s]), 32'(MN));
      check($sformatf("reset tc_dn[%0d]", s), 32'(tc_dn[s]), 1);
      check($sformatf("reset err_sticky[%0d]", s), 32'(err[s]), 0);
    end
    @(negedge clk);
    rst_ = 1;
    model_reset();
    cyc(1, 0, 0, 0, 5, 0);
    #1 check("load clamp low", 32'(dout[0]), 10);
    cyc(1, 0, 0, 0, 250, 0);
    #1 check("load clamp high", 32'(dout[1]), 20);
    check("load no ovf", 32'(ovf[0]), 0);
    cyc(1, 0, 0, 0, 18, 0);
    cyc(0, 1, 1, 4, 0, 0);
    #1 check("wrap up data_out", 32'(dout[0]), 11);
    check("wrap up ovf", 32'(ovf[0]), 1);
    check("wrap up err_sticky", 32'(err[0]), 1);
    check("sat up data_out", 32'(dout[1]), 20);
    cyc(0, 0, 0, 0, 0, 0);
    #1 check("ovf one cycle", 32'(ovf[0]), 0);
    cyc(1, 0, 0, 0, 20, 0);
    cyc(0, 1, 1, 1, 0, 1);
    #1 check("clear race err_sticky", 32'(err[0]), 1);
    check("clear race data_out", 32'(dout[0]), 10);
    cyc(0, 0, 0, 0, 0, 1);
    #1 check("clear err_sticky", 32'(err[0]), 0);
    cyc(1, 0, 0, 0, 12, 0);
    cyc(0, 1, 0, 5, 0, 0);
    #1 check("sat down data_out", 32'(dout[1]), 10);
    check("sat down unf", 32'(unf[1]), 1);
    check("wrap down data_out", 32'(dout[0]), 18);
    cyc(0, 1, 0, 5, 0, 0);
    #1 check("sat down repeat data_out", 32'(dout[1]), 10);
    check("sat down repeat unf", 32'(unf[1]), 1);
    repeat (5) cyc(0, 0, 1, 3, 0, 0);
    #1 check("hold data_out", 32'(dout[0]), 13);
    cyc(1, 1, 1, 7, 15, 0);
    #1 check("load priority", 32'(dout[0]), 15);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    ld_cnt = 0;
    count_enb = 1;
    updn_cnt = 1;
    step = 3;
    #2 rst_ = 0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("async reset data_out[%0d]", s), 32'(dout[s]), 32'(MN));
      check($sformatf("async reset tc_dn[%0d]", s), 32'(tc_dn[s]), 1);
      check($sformatf("async reset err_sticky[%0d]", s), 32'(err[s]), 0);
    end
    ld_cnt = 1;
    data_in = 17;
    repeat (2) @(posedge clk);
    #1 check("reset held data_out", 32'(dout[0]), 32'(MN));
    @(negedge clk);
    rst_ = 1;
    model_reset();
    drive(0, 1, 1, 2, 0, 0);
    #1 check("first edge after reset", 32'(dout[0]), 12);
    repeat (400)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/param_updn_counter.md
PARAM_UPDN_COUNTER -- requirements
Module: param_updn_counter

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 8, counter width in bits.
- STEP_W, 4, step input width in bits.
- MIN_VAL, 0, lower count bound.
- MAX_VAL, 2**WIDTH-1, upper count bound.
- SATURATE, 0, bound mode: 0 = wrap, 1 = clamp.

REQ-002 Parameter legality SHALL be MIN_VAL < MAX_VAL <= 2**WIDTH-1 and 2**STEP_W-1 <= MAX_VAL-MIN_VAL; violation SHALL stop elaboration with $error.

REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  load value.
- ld_cnt  in  1  load strobe.
- count_enb  in  1  count enable.
- updn_cnt  in  1  direction: 1 = up, 0 = down.
- step  in  STEP_W  unsigned increment/decrement amount.
- clr_err  in  1  clears err_sticky.
- data_out  out  WIDTH  registered count.
- tc_up  out  1  combinational; data_out == MAX_VAL.
- tc_dn  out  1  combinational; data_out == MIN_VAL.
- ovf  out  1  registered one-cycle pulse; up-count crossed MAX_VAL.
- unf  out  1  registered one-cycle pulse; down-count crossed MIN_VAL.
- err_sticky  out  1  registered; latched ovf|unf event.

Function
REQ-004 Priority per edge SHALL be: ld_cnt, then count_enb, then hold.
REQ-005 Load SHALL set data_out to data_in clamped into [MIN_VAL, MAX_VAL] on the next edge (1-cycle latency), regardless of SATURATE; a load SHALL never assert ovf or unf.
REQ-006 With ld_cnt=0 and count_enb=0, data_out, ovf=0 and unf=0 SHALL hold; tc_up and tc_dn SHALL follow data_out.
REQ-007 An up count SHALL compute sum = data_out + step at WIDTH+2 bits, with no truncation before bound comparison.
REQ-008 If sum <= MAX_VAL, data_out SHALL become sum.
REQ-009 If sum > MAX_VAL, data_out SHALL become MIN_VAL + (sum - MAX_VAL - 1) when SATURATE=0, or MAX_VAL when SATURATE=1; ovf SHALL pulse high for one cycle.
REQ-010 A down count SHALL compute diff = data_out - step at WIDTH+2 bits, signed.
REQ-011 If diff >= MIN_VAL, data_out SHALL become diff.
REQ-012 If diff < MIN_VAL, data_out SHALL become MAX_VAL - (MIN_VAL - diff - 1) when SATURATE=0, or MIN_VAL when SATURATE=1; unf SHALL pulse high for one cycle.
REQ-013 Saturate mode sitting at a bound and counting further SHALL hold the bound and SHALL still pulse ovf or unf.
REQ-014 step=0 with count_enb=1 SHALL leave data_out unchanged with no ovf or unf.
REQ-015 err_sticky SHALL set on any cycle where ovf or unf is set; it SHALL clear on clr_err=1 only if no new ovf or unf occurs that cycle, because set wins over clear.
REQ-016 A data_out value outside [MIN_VAL, MAX_VAL] is not reachable from reset, load or count and SHALL NOT need handling.

Reset
REQ-017 rst_=0 SHALL immediately, without a clock, force data_out=MIN_VAL, ovf=0, unf=0 and err_sticky=0; tc_dn SHALL then read 1.
REQ-018 During reset, ld_cnt and count_enb SHALL be ignored; reset asserted mid-count SHALL discard the pending update.
REQ-019 On rst_ deassertion, the first rising clk edge with rst_=1 SHALL perform a normal update.

Verification
REQ-020 The bench SHALL cover these directed scenarios (WIDTH=8, MIN_VAL=10, MAX_VAL=20, STEP_W=3 unless stated):
- Reset: rst_=0 mid-count with count_enb=1 -> data_out=10, tc_dn=1, err_sticky=0 asynchronously; held until rst_=1.
- Load clamp: data_in=5 -> data_out=10; data_in=250 -> data_out=20; no ovf, no unf.
- Wrap up, SATURATE=0: data_out=18, step=4, up -> data_out=11, ovf=1 for exactly one cycle, err_sticky=1.
- Saturate down, SATURATE=1: data_out=12, step=5, down -> data_out=10, unf=1; repeat -> stays 10, unf=1 again.
- Hold and priority: count_enb=0 -> data_out stable for 5 cycles; ld_cnt=1 with count_enb=1, data_in=15 -> data_out=15.
- Sticky clear race: clr_err=1 in the same cycle as a new ovf -> err_sticky stays 1; clr_err=1 next cycle with no event -> err_sticky=0.
